// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with pending/mask/mode registers and fixed priority.
// Define INTC_SYNC_EN to add a two-flop synchronizer on HWINT_I.
module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [3:2]      ADD_I,
  input  logic            WE_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  input  logic [NSRC-1:0] HWINT_I,
  input  logic            INT_ACK_I,
  output logic            IRQ_O
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, mode_q, pend_q, prev_q;
  logic [NSRC-1:0] pend_d, src, rise, active;
  logic [NSRC-1:0] w1c, ack_clr;
  logic [2:0]      id_q, id_d, win_id;
  logic            valid_q, valid_d;
  logic            irq_q, irq_d;
  logic            ack_take, eoi;
  logic            unused_dat;

  assign unused_dat = ^DAT_I[31:NSRC];

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= HWINT_I;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = HWINT_I;
`endif

  assign rise     = src & ~prev_q;
  assign active   = pend_q & mask_q;
  assign ack_take = (state_q == REQ) && INT_ACK_I;
  assign eoi      = (state_q == SVC) && WE_I
                    && (ADD_I == 2'b11);
  assign w1c      = (WE_I && ADD_I == 2'b01)
                    ? DAT_I[NSRC-1:0] : '0;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = 3'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = ack_take && (win_id == 3'(i))
                   && mode_q[i];
    end
  end

  // Edge bits: a new rise beats any clear in the same cycle.
  assign pend_d = (mode_q & (rise | (pend_q & ~w1c & ~ack_clr)))
                | (~mode_q & src);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          irq_d   = 1'b1;
        end
      end
      REQ: begin
        if (INT_ACK_I) begin
          state_d = SVC;
          irq_d   = 1'b0;
          valid_d = 1'b1;
          id_d    = win_id;
        end else if (~|active) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      SVC: begin
        irq_d = 1'b0;
        if (eoi) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      prev_q  <= src;
      if (WE_I && ADD_I == 2'b00) mask_q <= DAT_I[NSRC-1:0];
      if (WE_I && ADD_I == 2'b10) mode_q <= DAT_I[NSRC-1:0];
    end
  end

  always_comb begin
    DAT_O = '0;
    unique case (ADD_I)
      2'b00: DAT_O[NSRC-1:0] = mask_q;
      2'b01: DAT_O[NSRC-1:0] = pend_q;
      2'b10: DAT_O[NSRC-1:0] = mode_q;
      2'b11: DAT_O = {valid_q, 28'b0, id_q};
      default: DAT_O = '0;
    endcase
  end

  assign IRQ_O = irq_q;

endmodule
